sff_preset_arbiter: RTL
=======================

Name: sff_preset_arbiter

Overview:
- Controller for a bank of NUM set-able flops. Each flop has an active-low asynchronous set; the flop's clock is the same clk as this block.
- Sequences a staggered preset of the bank, one flop at a time, to limit simultaneous switching.
- After the preset, shares the bank's write port between two requesters using round-robin arbitration.
- Sits between the bank and its two producers in the techmap sequential test designs.

Parameters:
- NUM, 8, number of flops in the bank; also the width of the write data. Must be at least 2.
- PULSE, 2, number of cycles each set_n bit is held low. Must be at least 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run the preset sequence.
- req0  input  1  write request from requester 0.
- req1  input  1  write request from requester 1.
- wdata0  input  NUM  write data from requester 0.
- wdata1  input  NUM  write data from requester 1.
- set_n  output  NUM  per-flop active-low set lines to the bank; registered.
- bank_d  output  NUM  data to the bank; registered.
- bank_we  output  1  bank write enable; registered, one cycle wide per grant.
- gnt0  output  1  grant to requester 0; registered.
- gnt1  output  1  grant to requester 1; registered.
- busy  output  1  high while the preset sequence runs.
- done  output  1  high once the preset has completed; stays high until the next accepted start.

Behaviour:
- Reset (rst low, asynchronous):
  - set_n = all ones; bank_d = 0; bank_we = 0; gnt0 = gnt1 = 0; busy = 0; done = 0.
  - State = IDLE, idx = 0, cnt = 0, round-robin pointer = 0 (requester 0 preferred).
  - Reset asserted mid-preset aborts the sequence immediately; all set_n return high.
- States: IDLE, PRESET, GAP, RUN.
- IDLE:
  - req0/req1 are ignored; no grants.
  - start=1 at edge k: go to PRESET, idx = 0, cnt = 0, busy = 1 from edge k.
- PRESET:
  - set_n[idx] = 0 and all other set_n bits = 1.
  - set_n[0] is low for cycles k+1 .. k+PULSE.
  - cnt counts 0 .. PULSE-1; on wrap, idx increments.
  - Flop i is therefore low during cycles k+1+i*PULSE .. k+(i+1)*PULSE.
  - After the last index (NUM-1) completes, go to GAP.
  - start is ignored while in PRESET; requests are ignored and produce no grants.
- GAP:
  - Exactly one cycle with all set_n high and busy still 1.
  - Its purpose is recovery from set release before any write.
  - Then go to RUN with busy = 0 and done = 1 (both visible from edge k+1+NUM*PULSE+1).
- RUN:
  - A request sampled high at edge t produces, from edge t+1, bank_we = 1, the matching gnt = 1, and bank_d = that requester's wdata sampled at t.
  - All three are held for exactly one cycle per grant.
  - Only one requester has a request: it wins. A held request wins every cycle (back-to-back grants).
  - Both request: the requester indicated by the pointer wins. After any grant, the pointer points to the other requester.
  - No request: bank_we = 0, gnt0 = gnt1 = 0, bank_d holds its last value.
- start in RUN:
  - The restart has priority over requests in that cycle, so no grant is issued.
  - done is cleared, and the FSM goes to PRESET with idx = 0.
- gnt0 and gnt1 are never high together. bank_we = gnt0 | gnt1.
- set_n never has more than one bit low at a time.

Test Plan:
- Reset: hold rst low with start, req0 and req1 all 1 -> set_n = 8'hFF, bank_we = 0, gnt = 0, busy = 0, done = 0. Release rst -> state unchanged in IDLE, no grants.
- Preset walk (NUM=8, PULSE=2): start pulse at edge 0 -> set_n = 8'hFE in cycles 1-2, 8'hFD in cycles 3-4, ..., 8'h7F in cycles 15-16, 8'hFF in cycle 17 (GAP); done = 1 and busy = 0 from edge 18.
- Contention in RUN: req0 = req1 = 1 with wdata0 = 8'hA5, wdata1 = 8'h3C held 4 cycles -> grants alternate gnt0, gnt1, gnt0, gnt1; bank_d = A5, 3C, A5, 3C; bank_we = 1 in each of those cycles.
- Single requester: req1 held 3 cycles with wdata1 = 8'h11 -> gnt1 high 3 consecutive cycles, bank_d = 8'h11. Then req0 = req1 = 1 -> requester 0 wins first.
- Illegal timing: requests during IDLE or PRESET, and start during PRESET -> no grant; the walk continues unchanged and done asserts on the original schedule.
- Abort and restart: rst low at cycle 7 of a preset -> set_n = 8'hFF immediately, busy = 0. Separately, start together with req0 in RUN -> no grant, done = 0, set_n = 8'hFE in the next cycle.

Source files
------------

// File: rtl/sff_preset_arbiter.sv
// Purpose : staggered one-at-a-time preset of a set-able flop bank, then round-robin
//           sharing of the bank write port between two requesters.
// Latency : start -> busy same edge, first set_n low one edge later; request -> grant 1 edge.
// Backpr. : none; a request not granted in a cycle is simply not served, requester retries.
// Ports   : clk, rst (async active-low); start; req0/req1 + wdata0/wdata1 (NUM bits);
//           set_n (NUM, active-low sets), bank_d/bank_we (write port), gnt0/gnt1, busy, done.
module sff_preset_arbiter #(
   parameter int NUM   = 8,
   parameter int PULSE = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           req0,
   input  logic           req1,
   input  logic [NUM-1:0] wdata0,
   input  logic [NUM-1:0] wdata1,
   output logic [NUM-1:0] set_n,
   output logic [NUM-1:0] bank_d,
   output logic           bank_we,
   output logic           gnt0,
   output logic           gnt1,
   output logic           busy,
   output logic           done
);

   localparam int IW = (NUM   > 1) ? $clog2(NUM)   : 1;
   localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;

   typedef enum logic [1:0] {IDLE, PRESET, GAP, RUN} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   idx, idx_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            gap_ph, gap_ph_nx;
   logic            ptr, ptr_nx;     // 0: requester 0 preferred on contention
   logic            g0_nx, g1_nx;
   logic [NUM-1:0]  set_n_nx;
   logic [NUM-1:0]  one_hot;

   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      cnt_nx    = cnt;
      gap_ph_nx = gap_ph;
      ptr_nx    = ptr;
      g0_nx     = 1'b0;
      g1_nx     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = PRESET;
               idx_nx   = '0;
               cnt_nx   = '0;
            end
         end
         PRESET: begin
            if (cnt == CW'(PULSE - 1)) begin
               cnt_nx = '0;
               if (idx == IW'(NUM - 1)) begin
                  state_nx  = GAP;
                  idx_nx    = '0;
                  gap_ph_nx = 1'b0;
               end else begin
                  idx_nx = idx + 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         GAP: begin
            // set_n trails the FSM by one register stage, so the first GAP cycle
            // still emits the last pulse; the second is the all-high recovery cycle.
            if (gap_ph) begin
               state_nx = RUN;
            end else begin
               gap_ph_nx = 1'b1;
            end
         end
         RUN: begin
            if (start) begin
               // restart wins over any request in the same cycle
               state_nx = PRESET;
               idx_nx   = '0;
               cnt_nx   = '0;
            end else if (req0 && (!req1 || !ptr)) begin
               g0_nx  = 1'b1;
               ptr_nx = 1'b1;
            end else if (req1) begin
               g1_nx  = 1'b1;
               ptr_nx = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      one_hot  = {{(NUM-1){1'b0}}, 1'b1} << idx;
      set_n_nx = (state == PRESET) ? ~one_hot : '1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         idx     <= '0;
         cnt     <= '0;
         gap_ph  <= 1'b0;
         ptr     <= 1'b0;
         set_n   <= '1;
         bank_d  <= '0;
         bank_we <= 1'b0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         idx     <= idx_nx;
         cnt     <= cnt_nx;
         gap_ph  <= gap_ph_nx;
         ptr     <= ptr_nx;
         set_n   <= set_n_nx;
         gnt0    <= g0_nx;
         gnt1    <= g1_nx;
         bank_we <= g0_nx | g1_nx;
         if (g0_nx) begin
            bank_d <= wdata0;
         end else if (g1_nx) begin
            bank_d <= wdata1;
         end
         busy    <= (state_nx == PRESET) || (state_nx == GAP);
         done    <= (state_nx == RUN);
      end
   end

endmodule
